// File: rtl/reservation_station_pkg.sv
// Shared types for the reservation station: the decoded/renamed instruction
// packet, its NOP encoding, and the default sizing constants.
package reservation_station_pkg;

  localparam int XLEN        = 32;
  localparam int TAG_W       = 4;
  localparam int RS_SIZE_DEF = 4;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_func_e;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_value;
    logic [XLEN-1:0] rs2_value;
    logic [31:0]     inst;
    logic [4:0]      dest_reg_idx;
    alu_func_e       alu_func;
    logic            rd_mem;
    logic            wr_mem;
    logic            cond_branch;
    logic            uncond_branch;
    logic            halt;
    logic            illegal;
    logic            valid;
  } ID_EX_PACKET;

  function automatic ID_EX_PACKET nop_packet();
    ID_EX_PACKET p;
    p              = '0;
    p.dest_reg_idx = ZERO_REG;
    p.alu_func     = ALU_ADD;
    return p;
  endfunction

endpackage

// File: rtl/rs_psel.sv
// Fixed-priority one-hot selector: grants the lowest-index asserted request.
module rs_psel #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers renamed instructions until both operands are
// captured (at insert or via CDB wakeup), then dispatches lowest-index first.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE     = RS_SIZE_DEF,
  parameter int ROB_TAG_LEN = TAG_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   insert_en,
  input  ID_EX_PACKET            id_packet_in,
  input  logic [ROB_TAG_LEN-1:0] rs1_rob_tag,
  input  logic [ROB_TAG_LEN-1:0] rs2_rob_tag,
  input  logic [ROB_TAG_LEN-1:0] dest_rob_tag,
  input  logic                   cdb_valid,
  input  logic [ROB_TAG_LEN-1:0] cdb_tag,
  input  logic [XLEN-1:0]        cdb_value,
  input  logic                   fu_ready,
  input  logic                   squash,
  output logic                   rs_full,
  output logic                   issue_valid,
  output ID_EX_PACKET            issue_packet,
  output logic [ROB_TAG_LEN-1:0] issue_rob_tag
);

  typedef struct packed {
    logic                   busy;
    ID_EX_PACKET            packet;
    logic [ROB_TAG_LEN-1:0] dest_tag;
    logic [ROB_TAG_LEN-1:0] tag1;
    logic [ROB_TAG_LEN-1:0] tag2;
  } rs_entry_t;

  rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;

  logic [RS_SIZE-1:0] free_vec, ready_vec, alloc_gnt, sel_gnt;
  logic               any_free, any_ready, do_ins, fire;

  // Tag 0 means "value already valid" and must never be woken by the CDB.
  function automatic logic cdb_hit(input logic                   vld,
                                   input logic [ROB_TAG_LEN-1:0] ctag,
                                   input logic [ROB_TAG_LEN-1:0] t);
    return vld && (t != '0) && (t == ctag);
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i]  = ~ent_q[i].busy;
      ready_vec[i] = ent_q[i].busy && (ent_q[i].tag1 == '0) && (ent_q[i].tag2 == '0);
    end
  end

  rs_psel #(.N(RS_SIZE)) u_alloc_sel (.req(free_vec),  .gnt(alloc_gnt), .any(any_free));
  rs_psel #(.N(RS_SIZE)) u_issue_sel (.req(ready_vec), .gnt(sel_gnt),   .any(any_ready));

  assign rs_full     = ~any_free;
  assign issue_valid = any_ready;
  assign do_ins      = insert_en && any_free && !squash && id_packet_in.valid;
  assign fire        = any_ready && fu_ready;

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ent_q[i].busy) begin
        if (cdb_hit(cdb_valid, cdb_tag, ent_q[i].tag1)) begin
          ent_d[i].tag1             = '0;
          ent_d[i].packet.rs1_value = cdb_value;
        end
        if (cdb_hit(cdb_valid, cdb_tag, ent_q[i].tag2)) begin
          ent_d[i].tag2             = '0;
          ent_d[i].packet.rs2_value = cdb_value;
        end
        // Dispatch beats a same-cycle wakeup of the selected entry.
        if (fire && sel_gnt[i]) ent_d[i].busy = 1'b0;
      end else if (do_ins && alloc_gnt[i]) begin
        ent_d[i].busy     = 1'b1;
        ent_d[i].packet   = id_packet_in;
        ent_d[i].dest_tag = dest_rob_tag;
        ent_d[i].tag1     = rs1_rob_tag;
        ent_d[i].tag2     = rs2_rob_tag;
        if (cdb_hit(cdb_valid, cdb_tag, rs1_rob_tag)) begin
          ent_d[i].tag1             = '0;
          ent_d[i].packet.rs1_value = cdb_value;
        end
        if (cdb_hit(cdb_valid, cdb_tag, rs2_rob_tag)) begin
          ent_d[i].tag2             = '0;
          ent_d[i].packet.rs2_value = cdb_value;
        end
      end
      if (squash) ent_d[i].busy = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ent_q <= '0;
    else        ent_q <= ent_d;
  end

  always_comb begin
    issue_packet  = nop_packet();
    issue_rob_tag = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (sel_gnt[i]) begin
        issue_packet  = ent_q[i].packet;
        issue_rob_tag = ent_q[i].dest_tag;
      end
    end
  end

endmodule

// File: doc/reservation_station.md
# reservation_station

Holds decoded, renamed instructions between the issue stage and the functional units until both source operands are available. Each cycle it accepts at most one instruction from issue, captures missing operands from the common data bus (CDB), and dispatches at most one ready instruction to the execute stage. `rs_full` is fed back to issue as part of its stall condition.

## Interface
Parameters:
- `RS_SIZE`, 4: number of entries, at least 2.
- `ROB_TAG_LEN`, `` `ROB_TAG_LEN ``: width of a ROB tag. Tag 0 means "no dependency, value valid".

Ports (clock and reset first):
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `insert_en`  in  1  allocate an entry for `id_packet_in` this cycle.
- `id_packet_in`  in  `ID_EX_PACKET`  decoded instruction, with `rs1_value`/`rs2_value` already muxed by issue.
- `rs1_rob_tag`, `rs2_rob_tag`  in  `ROB_TAG_LEN` each  producer tags; 0 means the operand value is valid.
- `dest_rob_tag`  in  `ROB_TAG_LEN`  ROB slot allocated to the incoming instruction.
- `cdb_valid`  in  1  CDB broadcast valid.
- `cdb_tag`  in  `ROB_TAG_LEN`  CDB producer tag.
- `cdb_value`  in  `XLEN`  CDB result.
- `fu_ready`  in  1  execute stage accepts a dispatch this cycle.
- `squash`  in  1  flush on mispredict; clears all entries.
- `rs_full`  out  1  every entry is busy.
- `issue_valid`  out  1  `issue_packet` holds a ready instruction.
- `issue_packet`  out  `ID_EX_PACKET`  dispatched instruction with both operand values filled.
- `issue_rob_tag`  out  `ROB_TAG_LEN`  destination ROB tag of the dispatched instruction.

## Operation
- Each entry holds: `busy`, `packet`, `dest_tag`, `tag1`, `tag2`. An operand is ready when its tag is 0.
- Insert:
  - When `insert_en & ~rs_full & ~squash`, the lowest-index free entry is written at the clock edge.
  - Insert while `rs_full` is ignored. Issue is responsible for stalling; the RS does not assert any error.
  - Insert with `id_packet_in.valid == 0` is also ignored.
- Insert-time bypass: if `cdb_valid` and `cdb_tag` equals a nonzero incoming `rsN_rob_tag`, the entry is written with `cdb_value` and tag 0.
- Wakeup: on every edge with `cdb_valid`, each busy entry with `tagN == cdb_tag` (and `tagN != 0`) latches `cdb_value` into `rsN_value` and clears `tagN`. All entries are woken in parallel.
- Select:
  - `issue_valid` = OR of (busy & tag1 == 0 & tag2 == 0) over all entries.
  - `issue_packet` and `issue_rob_tag` come from the lowest-index ready entry; this is combinational from registered state.
  - The selected entry's `busy` clears on the edge where `issue_valid & fu_ready`.
- Stores are inserted like any other instruction. Their rs2 dependency is tracked the same way.
- Squash clears every `busy` bit at the edge and blocks insert that cycle. Squash has priority over insert, dispatch, and wakeup.
- `rs_full` = AND of all `busy` bits, taken from registered state. A dispatch in the same cycle does not deassert it combinationally.
- When `issue_valid == 0`, `issue_packet` is driven as a NOP: `valid = 0`, `dest_reg_idx = ZERO_REG`, all control bits 0.

## Timing
- Reset (`reset == 0`, asynchronous): all `busy` = 0, so `rs_full` = 0 and `issue_valid` = 0, and `issue_packet` is a NOP. `issue_rob_tag` = 0.
- Latency:
  - Insert with both tags 0: dispatchable in the cycle after the insert edge (1 cycle).
  - Wakeup by CDB at edge N: dispatchable in cycle N+1.
- Simultaneous events:
  - Dispatch and insert in one cycle: both happen. The freed slot is not reusable until the next cycle.
  - Dispatch and wakeup of the same entry in one cycle: dispatch wins and the entry is freed.
  - Reset deasserting mid-stream: no entry survives reset.
- Tag 0 is never matched on the CDB, even when `cdb_tag == 0`.

## Structure
- `RS_ENTRY` typedef (`busy`, `packet`, `dest_tag`, `tag1`, `tag2`) and `RS_SIZE` default go in `sys_defs.svh`, next to `ID_EX_PACKET`.
- Sub-module `rs_psel`: a parameterised fixed-priority (lowest index) one-hot selector. It is instantiated twice: once for free-entry allocation and once for ready-entry selection.

## Test plan
- Reset: hold `reset = 0`, then release → `rs_full = 0`, `issue_valid = 0`, `issue_packet.valid = 0`.
- Ready insert: insert ADD with both tags 0, `dest_rob_tag = 3`, `fu_ready = 1` → next cycle `issue_valid = 1`, `issue_rob_tag = 3`; the following cycle `issue_valid = 0`.
- Wakeup:
  - Insert with `rs1_rob_tag = 5`, then CDB `tag = 5`, `value = 0xDEAD` two cycles later.
  - Expected: the cycle after the CDB, `issue_packet.rs1_value = 0xDEAD`.
- Same-cycle bypass: insert with `rs2_rob_tag = 7` while CDB broadcasts `tag 7`, `value 0x42` → next cycle dispatch with `rs2_value = 0x42`.
- Full and priority:
  - Fill 4 entries with unresolved tags, then attempt a 5th insert.
  - Expected: `rs_full = 1` and the 5th insert is dropped.
  - Then wake entries 2 and 0 on the same edge → entry 0 is dispatched first, then entry 2.
- Squash and reset mid-operation:
  - Squash with 3 busy entries plus a concurrent insert → next cycle all entries are free and `issue_valid = 0`.
  - Repeat with async `reset = 0` mid-cycle → outputs clear immediately.
